// File: rtl/alarm_pkg.sv
// Shared types and BCD helpers for the alarm-clock control block.
// Optional snooze support is selected by the ALARM_SNOOZE_EN macro.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_TH,
    ST_SET_TM,
    ST_SET_AH,
    ST_SET_AM,
    ST_RING,
    ST_SNOOZE
  } alarm_state_t;

  typedef enum logic [1:0] {
    EF_NONE = 2'd0,
    EF_HOUR = 2'd1,
    EF_MIN  = 2'd2
  } edit_field_t;

  typedef struct packed {
    logic [3:0] dec;
    logic [3:0] one;
  } bcd_hour_t;

  typedef struct packed {
    logic [3:0] dec;
    logic [3:0] one;
  } bcd_min_t;

  localparam logic [3:0] HOUR_MAX_DEC = 4'd2;
  localparam logic [3:0] HOUR_MAX_ONE = 4'd3;
  localparam logic [3:0] MIN_MAX_DEC  = 4'd5;

  function automatic bcd_hour_t bcd_hour_inc(input bcd_hour_t h);
    bcd_hour_t r;
    r = h;
    if (h.dec == HOUR_MAX_DEC && h.one >= HOUR_MAX_ONE) begin
      r = '0;
    end else if (h.one == 4'd9) begin
      r.dec = h.dec + 4'd1;
      r.one = '0;
    end else begin
      r.one = h.one + 4'd1;
    end
    return r;
  endfunction

  // Minutes wrap 59 -> 00 without carrying into the hour field.
  function automatic bcd_min_t bcd_min_inc(input bcd_min_t m);
    bcd_min_t r;
    r = m;
    if (m.one == 4'd9) begin
      r.one = '0;
      r.dec = (m.dec == MIN_MAX_DEC) ? 4'd0 : m.dec + 4'd1;
    end else begin
      r.one = m.one + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_ctrl_tick_gen.sv
// Timebase prescaler: one-cycle tim_over every TICK_DIV enabled cycles.
module alarm_tick_gen #(
  parameter int unsigned TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic restart,
  output logic tim_over
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tim_over = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm-clock control: mode sequencing, time/alarm editing, watch load and ring.
// Define ALARM_SNOOZE_EN to add the SNOOZE state (btn_inc while ringing).
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 10000,
  parameter int unsigned RING_TICKS   = 60,
  parameter int unsigned SNOOZE_TICKS = 300
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_alarm,
  input  logic        tim_en,
  input  logic [3:0]  hourdec_now,
  input  logic [3:0]  hourone_now,
  input  logic [3:0]  mindec_now,
  input  logic [3:0]  minone_now,
  output logic        tim_over,
  output logic [3:0]  hourdec_init,
  output logic [3:0]  hourone_init,
  output logic [3:0]  mindec_init,
  output logic [3:0]  minone_init,
  output logic        load,
  output logic [15:0] disp_digits,
  output logic [1:0]  edit_field,
  output logic        alarm_on,
  output logic        ring
);

  localparam int unsigned TICK_MAX = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
  localparam int unsigned TW = $clog2(TICK_MAX + 1);
  localparam logic [TW-1:0] RING_LAST = TW'(RING_TICKS - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_TICKS - 1);
`endif

  alarm_state_t state, state_nx;
  edit_field_t  ef;
  bcd_hour_t    now_h, edit_h, alarm_h, init_h;
  bcd_min_t     now_m, edit_m, alarm_m, init_m;
  logic [TW-1:0] tick_cnt;
  logic match, match_q, match_rise, do_load, tick_run;

  assign now_h = {hourdec_now, hourone_now};
  assign now_m = {mindec_now, minone_now};

  assign match      = alarm_on && (now_h == alarm_h) && (now_m == alarm_m);
  assign match_rise = match && !match_q;
  assign do_load    = (state == ST_SET_TM) && btn_mode;
  assign tick_run   = tim_en && (state != ST_SET_TH) && (state != ST_SET_TM);

  alarm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rstn    (rstn),
    .run     (tick_run),
    .restart (do_load),
    .tim_over(tim_over)
  );

  assign hourdec_init = init_h.dec;
  assign hourone_init = init_h.one;
  assign mindec_init  = init_m.dec;
  assign minone_init  = init_m.one;
  assign edit_field   = ef;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ef          = EF_NONE;
    ring        = 1'b0;
    disp_digits = {now_h, now_m};
    case (state)
      ST_RUN: begin
        if (btn_mode)        state_nx = ST_SET_TH;
        else if (match_rise) state_nx = ST_RING;
      end
      ST_SET_TH: begin
        ef          = EF_HOUR;
        disp_digits = {edit_h, edit_m};
        if (btn_mode) state_nx = ST_SET_TM;
      end
      ST_SET_TM: begin
        ef          = EF_MIN;
        disp_digits = {edit_h, edit_m};
        if (btn_mode) state_nx = ST_SET_AH;
      end
      ST_SET_AH: begin
        ef          = EF_HOUR;
        disp_digits = {alarm_h, alarm_m};
        if (btn_mode) state_nx = ST_SET_AM;
      end
      ST_SET_AM: begin
        ef          = EF_MIN;
        disp_digits = {alarm_h, alarm_m};
        if (btn_mode) state_nx = ST_RUN;
      end
      ST_RING: begin
        ring = 1'b1;
        if (btn_mode)                                 state_nx = ST_RUN;
`ifdef ALARM_SNOOZE_EN
        else if (btn_inc)                             state_nx = ST_SNOOZE;
`endif
        else if (tim_over && tick_cnt == RING_LAST)   state_nx = ST_RUN;
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (btn_mode)                                 state_nx = ST_RUN;
        else if (tim_over && tick_cnt == SNOOZE_LAST) state_nx = ST_RING;
      end
`endif
      default: state_nx = ST_RUN;
    endcase
  end

  // One tick counter serves RING and SNOOZE; any state change clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edit_h   <= '0;
      edit_m   <= '0;
      alarm_h  <= '0;
      alarm_m  <= '0;
      init_h   <= '0;
      init_m   <= '0;
      load     <= 1'b0;
      alarm_on <= 1'b0;
      match_q  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      load    <= do_load;
      match_q <= match;
      if (do_load) begin
        init_h <= edit_h;
        init_m <= edit_m;
      end
      if (state == ST_RUN && btn_alarm) alarm_on <= ~alarm_on;
      if (state_nx != state)
        tick_cnt <= '0;
      else if (tim_over && (state == ST_RING || state == ST_SNOOZE))
        tick_cnt <= tick_cnt + TW'(1);
      case (state)
        ST_RUN: if (btn_mode) begin
          edit_h <= now_h;
          edit_m <= now_m;
        end
        ST_SET_TH: if (!btn_mode && btn_inc) edit_h  <= bcd_hour_inc(edit_h);
        ST_SET_TM: if (!btn_mode && btn_inc) edit_m  <= bcd_min_inc(edit_m);
        ST_SET_AH: if (!btn_mode && btn_inc) alarm_h <= bcd_hour_inc(alarm_h);
        ST_SET_AM: if (!btn_mode && btn_inc) alarm_m <= bcd_min_inc(alarm_m);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Randomized and directed bench for alarm_ctrl against a behavioural model
// that tracks time as integer hours/minutes.
module tb_alarm_ctrl;

  localparam int TD = 4;
  localparam int RT = 3;
  localparam int ST = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  localparam int M_RUN = 0, M_TH = 1, M_TM = 2, M_AH = 3, M_AM = 4, M_RING = 5, M_SNZ = 6;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_alarm = 1'b0, tim_en = 1'b0;
  logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
  logic tim_over, load, alarm_on, ring;
  logic [3:0] hourdec_init, hourone_init, mindec_init, minone_init;
  logic [15:0] disp_digits;
  logic [1:0] edit_field;

  int now_h = 0, now_m = 0;
  assign hourdec_now = 4'(now_h / 10);
  assign hourone_now = 4'(now_h % 10);
  assign mindec_now  = 4'(now_m / 10);
  assign minone_now  = 4'(now_m % 10);

  always #5 clk = ~clk;

  alarm_ctrl #(.TICK_DIV(TD), .RING_TICKS(RT), .SNOOZE_TICKS(ST)) dut (
    .clk(clk), .rstn(rstn), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_alarm(btn_alarm), .tim_en(tim_en),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .tim_over(tim_over),
    .hourdec_init(hourdec_init), .hourone_init(hourone_init),
    .mindec_init(mindec_init), .minone_init(minone_init),
    .load(load), .disp_digits(disp_digits), .edit_field(edit_field),
    .alarm_on(alarm_on), .ring(ring)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_st, m_pres, m_eh, m_em, m_ah, m_am, m_ih, m_im, m_ticks;
  bit m_load, m_aon, m_prev;

  function automatic logic [31:0] bcd4(input int h, input int m);
    return {16'h0, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic bit exp_tov();
    return tim_en && m_st != M_TH && m_st != M_TM && m_pres == TD - 1;
  endfunction

  function automatic logic [31:0] exp_disp();
    if (m_st == M_TH || m_st == M_TM) return bcd4(m_eh, m_em);
    if (m_st == M_AH || m_st == M_AM) return bcd4(m_ah, m_am);
    return bcd4(now_h, now_m);
  endfunction

  function automatic logic [31:0] exp_ef();
    if (m_st == M_TH || m_st == M_AH) return 1;
    if (m_st == M_TM || m_st == M_AM) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = M_RUN; m_pres = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
    m_ih = 0; m_im = 0; m_ticks = 0; m_load = 0; m_aon = 0; m_prev = 0;
  endtask

  task automatic model_step();
    bit tov, match, rise;
    tov   = exp_tov();
    match = m_aon && now_h == m_ah && now_m == m_am;
    rise  = match && !m_prev;
    m_prev = match;
    m_load = 0;
    if (m_st == M_TM && btn_mode) m_pres = 0;
    else if (tim_en && m_st != M_TH && m_st != M_TM) m_pres = (m_pres + 1) % TD;
    if (m_st == M_RUN && btn_alarm) m_aon = !m_aon;
    case (m_st)
      M_RUN: if (btn_mode) begin m_eh = now_h; m_em = now_m; m_st = M_TH; end
             else if (rise) begin m_st = M_RING; m_ticks = 0; end
      M_TH:  if (btn_mode) m_st = M_TM; else if (btn_inc) m_eh = (m_eh + 1) % 24;
      M_TM:  if (btn_mode) begin m_st = M_AH; m_load = 1; m_ih = m_eh; m_im = m_em; end
             else if (btn_inc) m_em = (m_em + 1) % 60;
      M_AH:  if (btn_mode) m_st = M_AM; else if (btn_inc) m_ah = (m_ah + 1) % 24;
      M_AM:  if (btn_mode) m_st = M_RUN; else if (btn_inc) m_am = (m_am + 1) % 60;
      M_RING: if (btn_mode) m_st = M_RUN;
              else if (SNZ && btn_inc) begin m_st = M_SNZ; m_ticks = 0; end
              else if (tov) begin m_ticks++; if (m_ticks == RT) m_st = M_RUN; end
      M_SNZ: if (btn_mode) m_st = M_RUN;
             else if (tov) begin m_ticks++; if (m_ticks == ST) begin m_st = M_RING; m_ticks = 0; end end
      default: m_st = M_RUN;
    endcase
  endtask

  task automatic check_outputs();
    check("tim_over", tim_over, exp_tov());
    check("load", load, m_load);
    check("init", {hourdec_init, hourone_init, mindec_init, minone_init}, bcd4(m_ih, m_im));
    check("disp", disp_digits, exp_disp());
    check("edit_field", edit_field, exp_ef());
    check("alarm_on", alarm_on, m_aon);
    check("ring", ring, m_st == M_RING);
  endtask

  // Called at posedge+1: drive, check before the edge, then advance the model.
  task automatic cyc(input bit m, input bit i, input bit a, input bit te);
    btn_mode = m; btn_inc = i; btn_alarm = a; tim_en = te;
    #1;
    check_outputs();
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic trigger_ring();
    now_h = 7; now_m = 29; cyc(0, 0, 0, 1);
    now_m = 30;            cyc(0, 0, 0, 1);
    check("ring_start", ring, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, ticks;
    bit timeout;
    model_reset();
    now_h = 9; now_m = 59;
    #12;
    check("rst_load", load, 0);
    check("rst_ring", ring, 0);
    check("rst_alarm_on", alarm_on, 0);
    check("rst_tim_over", tim_over, 0);
    check("rst_edit_field", edit_field, 0);
    check("rst_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 0);
    check("rst_disp", disp_digits, 16'h0959);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Prescaler: pulse every TD cycles, hold when tim_en=0
    cnt = 0;
    for (int k = 0; k < 4 * TD; k++) begin
      if (tim_over) cnt++;
      cyc(0, 0, 0, 1);
    end
    check("tick_count", cnt, 4);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);

    // 09:59 -> load 10:00
    cyc(1, 0, 0, 1);
    check("ef_th", edit_field, 1);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    check("ef_tm", edit_field, 2);
    check("disp_1059", disp_digits, 16'h1059);
    cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    check("load_pulse", load, 1);
    check("init_1000", {hourdec_init, hourone_init, mindec_init, minone_init}, 16'h1000);
    check("ef_ah", edit_field, 1);
    cyc(1, 1, 0, 1);
    check("mode_inc_drop", disp_digits, 16'h0000);
    check("load_once", load, 0);
    cyc(1, 0, 0, 1);

    // Wrap 23 -> 00, 59 -> 00 without hour carry
    now_h = 23; now_m = 59;
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    check("hour_wrap", disp_digits, 16'h0059);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    check("min_wrap", disp_digits, 16'h0000);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);

    // Set alarm 07:30 and arm it
    cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
    for (int k = 0; k < 7; k++) cyc(0, 1, 0, 1);
    cyc(1, 0, 0, 1);
    for (int k = 0; k < 30; k++) cyc(0, 1, 0, 1);
    check("alarm_0730", disp_digits, 16'h0730);
    cyc(1, 0, 0, 1);
    now_h = 7; now_m = 29;
    cyc(0, 0, 1, 1);
    check("armed", alarm_on, 1);

    // Ring auto-dismiss after RT ticks, no re-ring on the same minute
    trigger_ring();
    ticks = 0; timeout = 1;
    for (int k = 0; k < 200; k++) begin
      if (!ring) begin timeout = 0; break; end
      if (tim_over) ticks++;
      cyc(0, 0, 0, 1);
    end
    check("ring_timeout", timeout, 0);
    check("ring_ticks", ticks, RT);
    for (int k = 0; k < 3 * TD; k++) cyc(0, 0, 0, 1);
    check("no_rering", ring, 0);

    // Dismiss with btn_mode
    trigger_ring();
    cyc(1, 0, 0, 1);
    check("dismiss_ring", ring, 0);
    check("dismiss_ef", edit_field, 0);

    if (SNZ) begin
      trigger_ring();
      cyc(0, 1, 0, 1);
      check("snooze_quiet", ring, 0);
      ticks = 0; timeout = 1;
      for (int k = 0; k < 200; k++) begin
        if (ring) begin timeout = 0; break; end
        if (tim_over) ticks++;
        cyc(0, 0, 0, 1);
      end
      check("snooze_timeout", timeout, 0);
      check("snooze_ticks", ticks, ST);
      cyc(1, 0, 0, 1);
    end

    // Reset during SET_TM
    now_h = 12; now_m = 34;
    cyc(1, 0, 0, 1); cyc(0, 1, 0, 1); cyc(1, 0, 0, 1); cyc(0, 1, 0, 1);
    btn_mode = 0; btn_inc = 0;
    rstn = 1'b0;
    #1;
    check("mid_rst_load", load, 0);
    check("mid_rst_ring", ring, 0);
    check("mid_rst_alarm_on", alarm_on, 0);
    check("mid_rst_ef", edit_field, 0);
    check("mid_rst_init", {hourdec_init, hourone_init, mindec_init, minone_init}, 0);
    check("mid_rst_tim_over", tim_over, 0);
    check("mid_rst_disp", disp_digits, 16'h1234);
    @(posedge clk); #1;
    check("mid_rst_noload", load, 0);
    rstn = 1'b1;
    model_reset();

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 1) begin now_h = m_ah; now_m = m_am; end
        else begin now_h = $urandom_range(0, 23); now_m = $urandom_range(0, 59); end
      end
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
